stop_it_game: RTL and testbench

STOP_IT_GAME -- requirements
Module: stop_it_game

---
 rtl/stop_it_pkg.sv | 27 ++
 rtl/lfsr5.sv | 23 ++
 rtl/stop_it_game.sv | 120 ++++++++++++
 tb/tb_stop_it_game.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/stop_it_pkg.sv
// Shared types and constants for the stop-it reaction game.
// Holds the FSM state enum, the counter geometry and the LFSR seed.
package stop_it_pkg;

    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_MAX    = 5'd31;
    localparam logic [CNT_W-1:0] TARGET_MAX = 5'd30;
    localparam logic [CNT_W-1:0] LFSR_SEED  = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    // The LFSR never yields 0, so only 31 needs folding down.
    function automatic logic [CNT_W-1:0] sat_target(
        input logic [CNT_W-1:0] v
    );
        return (v > TARGET_MAX) ? TARGET_MAX : v;
    endfunction

endpackage

// File: rtl/lfsr5.sv
// Free-running 5-bit Fibonacci LFSR, polynomial x^5 + x^3 + 1.
// Steps every clock; synchronous reset reloads the seed.
module lfsr5
    import stop_it_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] q
);

    logic [4:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[3:0], r_q[4] ^ r_q[2]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/stop_it_game.sv
// Stop-it game controller: player stops an external counter on a
// pseudo-random target; drives counter control and result flags.
module stop_it_game
    import stop_it_pkg::*;
(
    input  logic             clk_4_i,
    input  logic             rst_i,
    input  logic             go_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             counter_en_o,
    output logic             counter_clr_o,
    output logic [CNT_W-1:0] target_o,
    output logic [CNT_W-1:0] captured_o,
    output logic             win_o,
    output logic             lose_o,
    output logic             blink_o
);

    state_t           r_state;
    state_t           w_next;
    logic             r_go_d;
    logic             r_stop_d;
    logic             r_rst_d;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_captured;
    logic             r_blink;
    logic [CNT_W-1:0] w_lfsr;
    logic             w_go_edge;
    logic             w_stop_edge;
    logic             w_go_ok;
    logic             w_cap_ok;
    logic             w_result;

    lfsr5 u_lfsr (
        .clk (clk_4_i),
        .rst (rst_i),
        .q   (w_lfsr)
    );

    // First cycle after reset is masked so a button held through
    // reset must be released and pressed again.
    assign w_go_edge   = go_i & ~r_go_d & ~r_rst_d;
    assign w_stop_edge = stop_i & ~r_stop_d & ~r_rst_d;

    assign w_go_ok  = w_go_edge &
                      ((r_state == S_IDLE) || (r_state == S_WIN) ||
                       (r_state == S_LOSE));
    assign w_cap_ok = (r_state == S_RUN) &&
                      (w_stop_edge || (count_i == CNT_MAX));
    assign w_result = (w_next == S_WIN) || (w_next == S_LOSE);

    always_ff @(posedge clk_4_i) begin
        r_rst_d <= rst_i;
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_go_d   <= 1'b0;
            r_stop_d <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_go_d   <= go_i;
            r_stop_d <= stop_i;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_go_edge) w_next = S_CLEAR;
            S_CLEAR: w_next = S_RUN;
            S_RUN: begin
                if (w_stop_edge)             w_next = S_CHECK;
                else if (count_i == CNT_MAX) w_next = S_LOSE;
            end
            S_CHECK: w_next = (r_captured == r_target) ? S_WIN : S_LOSE;
            S_WIN,
            S_LOSE:  if (w_go_edge) w_next = S_CLEAR;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        counter_en_o  = 1'b0;
        counter_clr_o = 1'b0;
        win_o         = 1'b0;
        lose_o        = 1'b0;
        unique case (1'b1)
            (r_state == S_CLEAR): counter_clr_o = 1'b1;
            (r_state == S_RUN):   counter_en_o  = 1'b1;
            (r_state == S_WIN):   win_o         = 1'b1;
            (r_state == S_LOSE):  lose_o        = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_4_i) begin
        if (rst_i) begin
            r_target   <= '0;
            r_captured <= '0;
            r_blink    <= 1'b0;
        end else begin
            if (w_go_ok) begin
                r_target   <= sat_target(w_lfsr);
                r_captured <= '0;
            end else if (w_cap_ok) begin
                r_captured <= count_i;
            end
            if (w_result) begin
                r_blink <= (w_next == r_state) ? ~r_blink : 1'b1;
            end else begin
                r_blink <= 1'b0;
            end
        end
    end

    assign target_o   = r_target;
    assign captured_o = r_captured;
    assign blink_o    = r_blink;

endmodule

// File: tb/tb_stop_it_game.sv
// Directed bench for stop_it_game: vector table plus a hand-written
// reset/LFSR-restart sequence.
module tb_stop_it_game;

    localparam int T   = -2;
    localparam int TM1 = -3;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       stop;
    logic [4:0] cnt;
    logic       en;
    logic       clr;
    logic [4:0] tgt;
    logic [4:0] cap;
    logic       win;
    logic       lose;
    logic       blink;

    always #5 clk = ~clk;

    stop_it_game dut (
        .clk_4_i       (clk),
        .rst_i         (rst),
        .go_i          (go),
        .stop_i        (stop),
        .count_i       (cnt),
        .counter_en_o  (en),
        .counter_clr_o (clr),
        .target_o      (tgt),
        .captured_o    (cap),
        .win_o         (win),
        .lose_o        (lose),
        .blink_o       (blink)
    );

    typedef struct {
        bit rst;
        bit go;
        bit stop;
        int cnt;
        bit lat;
        bit en;
        bit clr;
        bit win;
        bit lose;
        bit blink;
        int cap;
    } vec_t;

    vec_t       v[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] m_lfsr = 5'd1;
    int         exp_tgt = 0;

    always @(posedge clk)
        m_lfsr <= rst ? 5'd1 : {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};

    function automatic int sat(input logic [4:0] x);
        return (x > 5'd30) ? 30 : int'(x);
    endfunction

    function automatic vec_t mk(
        input bit r, input bit g, input bit s, input int c, input bit l,
        input bit e, input bit k, input bit w, input bit o, input bit b,
        input int p
    );
        vec_t t;
        t = '{r, g, s, c, l, e, k, w, o, b, p};
        return t;
    endfunction

    function automatic int resolve(input int x);
        if (x == T)   return exp_tgt;
        if (x == TM1) return exp_tgt - 1;
        return x;
    endfunction

    task automatic chk(input int row, input string nm,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL row %0d %s: got %0d expected %0d",
                     row, nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit g, input bit s,
                        input int c, input bit l);
        if (r)      exp_tgt = 0;
        else if (l) exp_tgt = sat(m_lfsr);
        rst  = r;
        go   = g;
        stop = s;
        cnt  = 5'(resolve(c));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int row, input bit e, input bit k,
                              input bit w, input bit o, input bit b,
                              input int p);
        chk(row, "counter_en", int'(en), int'(e));
        chk(row, "counter_clr", int'(clr), int'(k));
        chk(row, "win", int'(win), int'(w));
        chk(row, "lose", int'(lose), int'(o));
        chk(row, "blink", int'(blink), int'(b));
        chk(row, "target", int'(tgt), exp_tgt);
        chk(row, "captured", int'(cap), resolve(p));
    endtask

    initial begin
        rst  = 1'b1;
        go   = 1'b0;
        stop = 1'b0;
        cnt  = 5'd0;

        //           rst go st cnt lat en clr win lose blk cap
        v.push_back(mk(1, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 0, 0,  1,  0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 0, 0,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 5,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 1, T,  0,  0, 0, 0, 0, 0, T));
        v.push_back(mk(0, 0, 1, 0,  0,  0, 0, 1, 0, 1, T));
        v.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 0, 0, T));
        v.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 0, 1, T));
        v.push_back(mk(0, 1, 0, 0,  1,  0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 1, TM1, 0, 0, 0, 0, 0, 0, TM1));
        v.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 1, 1, TM1));
        v.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 1, 0, TM1));
        v.push_back(mk(0, 1, 0, 0,  1,  0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 31, 0,  0, 0, 0, 1, 1, 31));
        v.push_back(mk(0, 0, 1, 0,  0,  0, 0, 0, 1, 0, 31));
        v.push_back(mk(0, 1, 0, 0,  1,  0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 1, 31, 0,  0, 0, 0, 0, 0, 31));
        v.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 1, 1, 31));
        v.push_back(mk(0, 1, 1, 0,  1,  0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 1, 0,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 1, T,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 1, 0,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 1, T,  0,  0, 0, 0, 0, 0, T));
        v.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 0, 1, T));

        for (int i = 0; i < v.size(); i++) begin
            step(v[i].rst, v[i].go, v[i].stop, v[i].cnt, v[i].lat);
            expect_out(i, v[i].en, v[i].clr, v[i].win,
                       v[i].lose, v[i].blink, v[i].cap);
            if (v[i].lat) begin
                chk(i, "target_range", int'(tgt >= 5'd1 && tgt <= 5'd30), 1);
            end
        end

        // Reset mid-RUN with go held through reset.
        step(0, 1, 0, 0, 1);
        expect_out(100, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 3, 0);
        expect_out(101, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 3, 0);
        expect_out(102, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        expect_out(103, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        expect_out(104, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out(105, 0, 0, 0, 0, 0, 0);
        // LFSR restarted at 1 and stepped 1->2->4->9 since reset.
        step(0, 1, 0, 0, 1);
        expect_out(106, 0, 1, 0, 0, 0, 0);
        chk(106, "lfsr_restart_target", int'(tgt), 9);
        step(0, 0, 0, 0, 0);
        expect_out(107, 1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
